pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Stall/flush scheduler for the 5-stage MIPS pipeline; sits beside the forwarding unit and owns the PC, IF/ID and ID/EX write-enables. It resolves load-use interlocks, EX-resolved taken branches, and occupancy of the multi-cycle multiply/divide unit (MDU). The MDU side is a down-counter that sequences each mult/div and holds dependent instructions in ID until HI/LO is ready.

## Interface
- MUL_LAT, 4: MDU cycles for mult/multu, 1..63
- DIV_LAT, 32: MDU cycles for div/divu, 1..63
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt
- id_md_op  in  2  00 none, 01 mult, 10 div, 11 mfhi/mflo/mthi/mtlo (HI/LO access)
- ex_rw  in  5  destination register of the instruction in EX
- ex_reg_write  in  1  EX instruction writes the register file
- ex_memtoreg  in  1  EX instruction is a load
- ex_br_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to nop
- idex_bubble  out  1  load nop into ID/EX
- md_start  out  1  one-cycle MDU start pulse, registered
- md_is_div  out  1  operation of the current MDU run, registered
- md_busy  out  1  MDU running, HI/LO not yet valid, registered

## Operation
- lu_hz = ex_memtoreg & ex_reg_write & (ex_rw!=0) & ((id_use_rs & id_rs==ex_rw) | (id_use_rt & id_rt==ex_rw)).
- md_hz = (id_md_op!=00) & md_busy.
- stall = (lu_hz | md_hz) & ~ex_br_taken.
- Priority: rst > ex_br_taken > stall > run.
  - rst: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  - taken branch: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Any stall is dropped because the ID instruction is wrong-path.
  - stall: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - run: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- issue = (id_md_op==01 | id_md_op==10) & ~stall & ~ex_br_taken & ~rst.
- MDU FSM, with cnt a 6-bit register:
  - IDLE (cnt==0) -> BUSY on issue: cnt<=LAT (MUL_LAT or DIV_LAT), md_start<=1, md_is_div<=(id_md_op==10).
  - BUSY: cnt decrements by 1 each cycle; md_start<=0.
  - BUSY -> IDLE when cnt goes 1->0.
  - A new mult/div in ID while BUSY stalls through md_hz, so issue in BUSY is impossible.
- md_busy = (cnt!=0), registered. md_is_div holds until the next issue.
- A taken branch never cancels an MDU run already in BUSY; that run belongs to an older instruction.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM and lu_hz clears. With no MDU hazard, run resumes in the next cycle.

## Timing
- Combinational outputs (pc_write, ifid_write, ifid_flush, idex_bubble) respond in the same cycle as their inputs.
- Reset values of the registered outputs: md_start=0, md_is_div=0, md_busy=0, cnt=0.
- Reset mid-run: cnt, md_busy and md_start are 0 after the reset edge; no completion is signalled.
- Issue at edge T:
  - md_start=1 for cycle T+1 only.
  - md_busy=1 for cycles T+1 .. T+LAT, and 0 from T+LAT+1.
- An HI/LO op entering ID at T+1 stalls for LAT cycles and passes to EX at the edge ending cycle T+LAT+1.
- LAT=1 is legal: busy for one cycle and start coincides with busy.

## Configuration
- PIPE_MDU_EN defined: multi-cycle MDU scheduling as above.
- PIPE_MDU_EN undefined:
  - id_md_op is ignored and md_hz=0.
  - md_start, md_is_div and md_busy are tied 0.
  - No counter is built; only the load-use and branch logic remain.

## Test plan
- After reset release, no hazards: all stall/flush outputs idle (pc_write=1, ifid_write=1, flush=0, bubble=0) and md_busy=0 the first cycle after rst falls.
- lw $5 in EX (ex_rw=5, ex_memtoreg=1, ex_reg_write=1), ID reads rs=5 -> 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1. Same with ex_rw=0 -> no stall.
- ex_br_taken=1 together with lu_hz=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall.
- MUL_LAT=4: mult issued at edge T, mflo in ID at T+1 -> md_start one cycle, md_busy 4 cycles, mflo stalled 4 cycles, issues at the edge ending cycle T+5. Repeat with div and DIV_LAT=32 -> md_is_div=1, 32 busy cycles.
- Taken branch in EX while mult sits in ID -> no md_start and cnt stays 0. rst asserted with cnt=10 -> md_busy=0 the next cycle.
- Build without PIPE_MDU_EN: mult followed by mflo -> no stall, md_* outputs constant 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: PC/IF-ID/ID-EX stall-flush scheduler with optional MDU sequencer (enable with PIPE_MDU_EN).
// Rev 1.0
`default_nettype none

module pipe_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [1:0] id_md_op,
  input  logic [4:0] ex_rw,
  input  logic       ex_reg_write,
  input  logic       ex_memtoreg,
  input  logic       ex_br_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_busy
);

  logic lu_hz;
  logic md_hz;
  logic stall;

  assign lu_hz = ex_memtoreg && ex_reg_write && (ex_rw != 5'd0) &&
                 ((id_use_rs && (id_rs == ex_rw)) || (id_use_rt && (id_rt == ex_rw)));
  assign stall = (lu_hz || md_hz) && !ex_br_taken;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_br_taken) begin
      // ID holds a wrong-path instruction, so any pending stall is moot
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef PIPE_MDU_EN
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

  md_state_t  state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       start_q, start_nx;
  logic       is_div_q, is_div_nx;
  logic       busy_q;
  logic       issue;

  assign md_hz = (id_md_op != 2'b00) && busy_q;
  assign issue = ((id_md_op == 2'b01) || (id_md_op == 2'b10)) && !stall && !ex_br_taken && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= 6'd0;
      start_q  <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      start_q  <= start_nx;
      is_div_q <= is_div_nx;
      busy_q   <= (cnt_nx != 6'd0);
    end
  end

  // A run in BUSY is never cancelled by a branch: it belongs to an older instruction
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    start_nx  = 1'b0;
    is_div_nx = is_div_q;
    case (state)
      MD_IDLE: begin
        if (issue) begin
          state_nx  = MD_BUSY;
          cnt_nx    = (id_md_op == 2'b10) ? DIV_CNT : MUL_CNT;
          start_nx  = 1'b1;
          is_div_nx = (id_md_op == 2'b10);
        end
      end
      MD_BUSY: begin
        cnt_nx = cnt - 6'd1;
        if (cnt == 6'd1) state_nx = MD_IDLE;
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  assign md_start  = start_q;
  assign md_is_div = is_div_q;
  assign md_busy   = busy_q;
`else
  logic unused_mdu;

  assign unused_mdu = ^{clk, id_md_op, 6'(MUL_LAT), 6'(DIV_LAT)};
  assign md_hz      = 1'b0;
  assign md_start   = 1'b0;
  assign md_is_div  = 1'b0;
  assign md_busy    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of pipe_stall_ctrl; MDU sequences run only when PIPE_MDU_EN is defined.
// Rev 1.0
`default_nettype none

module tb_pipe_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RESET = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic       id_use_rs, id_use_rt;
  logic [1:0] id_md_op;
  logic       ex_reg_write, ex_memtoreg, ex_br_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic       md_start, md_is_div, md_busy;

  int n_cmp = 0;
  int n_bad = 0;

  wire [3:0] ctl = {pc_write, ifid_write, ifid_flush, idex_bubble};
  wire [2:0] md  = {md_start, md_is_div, md_busy};

  pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_op(id_md_op), .ex_rw(ex_rw), .ex_reg_write(ex_reg_write),
    .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_start(md_start), .md_is_div(md_is_div),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_md_op = 2'b00; ex_rw = 5'd0; ex_reg_write = 1'b0; ex_memtoreg = 1'b0;
    ex_br_taken = 1'b0;
  endtask

  // Load in EX writing ex_rw; inputs are driven mid-cycle (negedge)
  task automatic set_load(input logic [4:0] rw);
    ex_rw = rw; ex_reg_write = 1'b1; ex_memtoreg = 1'b1;
  endtask

`ifdef PIPE_MDU_EN
  // Issue op at the next edge T, then hold an HI/LO access in ID from T+1
  task automatic mdu_run(input string tag, input logic [1:0] op, input int lat, input logic is_div);
    id_md_op = op;
    #1 check({tag, "_issue_ctl"}, 8'(ctl), 8'(C_RUN));
    @(negedge clk);
    id_md_op = 2'b11;
    for (int i = 1; i <= lat + 1; i++) begin
      #1;
      check({tag, "_md"}, 8'(md), 8'({(i == 1), is_div, (i <= lat)}));
      check({tag, "_ctl"}, 8'(ctl), 8'((i <= lat) ? C_STALL : C_RUN));
      @(negedge clk);
    end
    id_md_op = 2'b00;
    #1 check({tag, "_done_md"}, 8'(md), 8'({1'b0, is_div, 1'b0}));
    @(negedge clk);
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 8'(ctl), 8'(C_RESET));
    check("reset_md", 8'(md), 8'd0);

    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_ctl", 8'(ctl), 8'(C_RUN));
    check("idle_md", 8'(md), 8'd0);

    // load-use on rs, then the load moves on and run resumes
    set_load(5'd5); id_rs = 5'd5; id_use_rs = 1'b1;
    #1 check("lu_rs", 8'(ctl), 8'(C_STALL));
    @(negedge clk);
    clear_inputs(); id_rs = 5'd5; id_use_rs = 1'b1;
    #1 check("lu_after", 8'(ctl), 8'(C_RUN));

    clear_inputs(); set_load(5'd9); id_rt = 5'd9; id_use_rt = 1'b1;
    #1 check("lu_rt", 8'(ctl), 8'(C_STALL));
    id_use_rt = 1'b0;
    #1 check("lu_rt_unused", 8'(ctl), 8'(C_RUN));

    clear_inputs(); set_load(5'd0); id_use_rs = 1'b1; id_use_rt = 1'b1;
    #1 check("lu_r0", 8'(ctl), 8'(C_RUN));

    clear_inputs(); set_load(5'd7); ex_reg_write = 1'b0; id_rs = 5'd7; id_use_rs = 1'b1;
    #1 check("lu_nowrite", 8'(ctl), 8'(C_RUN));

    clear_inputs(); ex_rw = 5'd7; ex_reg_write = 1'b1; id_rs = 5'd7; id_use_rs = 1'b1;
    #1 check("alu_fwd", 8'(ctl), 8'(C_RUN));

    clear_inputs(); set_load(5'd3); id_rs = 5'd4; id_rt = 5'd3; id_use_rs = 1'b1;
    #1 check("lu_mismatch", 8'(ctl), 8'(C_RUN));

    clear_inputs(); set_load(5'd5); id_rs = 5'd5; id_use_rs = 1'b1; ex_br_taken = 1'b1;
    #1 check("br_over_lu", 8'(ctl), 8'(C_FLUSH));

    clear_inputs(); ex_br_taken = 1'b1;
    #1 check("br_only", 8'(ctl), 8'(C_FLUSH));

    rst = 1'b1;
    #1 check("rst_over_br", 8'(ctl), 8'(C_RESET));
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    @(negedge clk);

`ifdef PIPE_MDU_EN
    mdu_run("mult", 2'b01, MUL_LAT, 1'b0);
    mdu_run("div", 2'b10, DIV_LAT, 1'b1);

    // taken branch with mult in ID: no issue, md_is_div keeps the last run's value
    id_md_op = 2'b01; ex_br_taken = 1'b1;
    #1 check("br_mult_ctl", 8'(ctl), 8'(C_FLUSH));
    @(negedge clk);
    clear_inputs();
    #1 check("br_mult_md", 8'(md), 8'b010);
    @(negedge clk);
    #1 check("br_mult_md2", 8'(md), 8'b010);

    // reset in the middle of a div run (cnt=10 at T+23)
    id_md_op = 2'b10;
    @(negedge clk);
    id_md_op = 2'b00;
    repeat (22) @(negedge clk);
    #1 check("div_mid_md", 8'(md), 8'b011);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_md", 8'(md), 8'd0);
    check("rst_mid_ctl", 8'(ctl), 8'(C_RESET));
    rst = 1'b0;
    @(negedge clk);
    #1 check("rst_mid_after", 8'(md), 8'd0);
`else
    // without the MDU, mult followed by mflo never stalls
    id_md_op = 2'b01;
    #1 check("nomdu_mult", 8'(ctl), 8'(C_RUN));
    @(negedge clk);
    id_md_op = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("nomdu_mflo_ctl", 8'(ctl), 8'(C_RUN));
      check("nomdu_md", 8'(md), 8'd0);
      @(negedge clk);
    end
    id_md_op = 2'b10;
    @(negedge clk);
    #1 check("nomdu_div_md", 8'(md), 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
